seg_display_arbiter: RTL
========================

Name: seg_display_arbiter

Overview:
- Shares the single 4-digit multiplexed 7-segment display between three content sources:
  - 0 = digit-entry view (player's secret or guess).
  - 1 = result view ("2LO"/"2HI"/guess count).
  - 2 = banner view ("PL 1"/"PL 2").
- Owns anode strobing and the refresh prescaler, so game logic only presents 4 cathode patterns plus a request.
- Sits between the game controller and the board's anodes/cathods pins.

Parameters:
- REFRESH_DIV, 25000: clock cycles per digit slot; legal range ≥ 2.
- MIN_FRAMES, 8: minimum full scan frames a grant is held before any preemption or release; legal range ≥ 1.
- BLINK_FRAMES, 50: frames per blink half-period (used only with SEG_BLINK_EN).

Ports:
- clock  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  3  request per source; bit i = source i; level-sensitive.
- seg0  in  32  source 0 patterns {d3,d2,d1,d0}, 8 bits each, active-low segments, d3 = leftmost digit.
- seg1  in  32  source 1 patterns, same format.
- seg2  in  32  source 2 patterns, same format.
- grant  out  3  one-hot current owner; 3'b000 when idle.
- frame_tick  out  1  one-cycle pulse on the last cycle of each full frame (digit 0 slot ends).
- anodes  out  4  active-low digit enables; exactly one bit low at all times after reset.
- cathods  out  8  active-low segment pattern for the enabled digit.

Behaviour:
- Reset (async, reset_n low), all registered:
  - prescaler = 0; digit index = 3; state = IDLE; hold count = 0.
  - grant = 000; anodes = 4'b0111; cathods = 8'hFF; frame_tick = 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - slot_tick is asserted when the count equals REFRESH_DIV-1.
- Scan:
  - On slot_tick, digit index steps 3→2→1→0→3.
  - anodes has bit[index] low, all other bits high.
  - cathods registered on the same edge: pattern of the new index from the granted source, or 8'hFF in IDLE.
  - Latency: 1 clock from index change to both outputs; anodes and cathods always change together.
- Frame boundary = slot_tick while index == 0.
  - frame_tick is asserted that cycle.
  - Hold count increments per frame and saturates at MIN_FRAMES.
- Source patterns are sampled live at each slot (no snapshot); sources keep seg stable while requesting.
- FSM states:
  - IDLE: if any req at a frame boundary, grant the highest-index requester (priority 2 > 1 > 0), go to OWN, hold = 0.
  - OWN(i): grant only changes at a frame boundary.
    - If hold < MIN_FRAMES: keep i, regardless of req.
    - Else if a higher-priority source requests: switch to it, hold = 0.
    - Else if req[i] low: switch to the highest remaining requester, or go to IDLE if none.
    - Else keep i.
- Requests asserted and dropped between frame boundaries are never seen.
  - Required: a 1-cycle pulse on req is lost (sources hold req).
- Simultaneous requests: fixed priority only; no round-robin.
- Reset mid-frame: immediate return to the reset values above; no partial frame completes.

Optional Feature:
- Macro: SEG_BLINK_EN.
- When defined:
  - Adds input blink (3 bits).
  - While the owner's blink bit is high, cathods are forced to 8'hFF during alternate BLINK_FRAMES-frame periods; the first period after blink rises is lit.
  - The blink frame counter resets on grant change or on blink falling.
  - This serves the win-state flash.
- When undefined: no blink port, no counter; outputs are as above.

Decomposition:
- Shared package seg_pkg:
  - digit-count constant (4).
  - SEG_BLANK = 8'hFF.
  - hex-to-segment constants 0..F, and glyph constants for P, L, H, I, O.
  - source index constants SRC_ENTRY = 0, SRC_RESULT = 1, SRC_BANNER = 2.
- One sub-module, seg_scan_timer: prescaler, digit index, slot_tick, frame_tick.
- Arbitration FSM and output muxing stay in the top module.

Test Plan (REFRESH_DIV = 4, MIN_FRAMES = 2):
- Reset release with no req:
  - anodes sequence 0111, 1011, 1101, 1110, each held 4 clocks.
  - cathods stay FF; frame_tick every 16 clocks.
- req = 001 with seg0 = 32'hC0F9A4B0, raised mid-frame:
  - grant = 001 only after the next frame boundary.
  - Next frame cathods = C0, F9, A4, B0 on anodes 0111, 1011, 1101, 1110.
- Owner 0 granted; req[2] rises 1 frame later:
  - grant stays 001 until hold reaches 2.
  - Then grant = 100 at that boundary; banner patterns appear.
- req = 110 rising together in IDLE:
  - grant = 100.
  - Drop req[2] after 3 frames: grant = 010 at the next boundary.
- Owner drops req, nothing else pending, hold ≥ 2:
  - grant = 000 at the boundary; cathods FF.
- reset_n low mid-slot:
  - Outputs go to reset values asynchronously; after release, scanning restarts at index 3.
- With SEG_BLINK_EN, BLINK_FRAMES = 2, blink[1] = 1, owner 1:
  - Lit 2 frames, blank (FF) 2 frames, repeating.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment display arbiter.
// Contents: digit count, blank pattern, hex and glyph segment codes (active-low,
// bit 7 = decimal point), source index constants, arbitration state type,
// hex_to_seg and top_req helper functions.
package seg_pkg;

    localparam int DIGITS = 4;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Packed table of hex digits F..0; entry n lives at bits [n*8 +: 8].
    localparam logic [127:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [7:0] SEG_P = 8'h8C;
    localparam logic [7:0] SEG_L = 8'hC7;
    localparam logic [7:0] SEG_H = 8'h89;
    localparam logic [7:0] SEG_I = 8'hF9;
    localparam logic [7:0] SEG_O = 8'hC0;

    localparam logic [1:0] SRC_ENTRY  = 2'd0;
    localparam logic [1:0] SRC_RESULT = 2'd1;
    localparam logic [1:0] SRC_BANNER = 2'd2;

    typedef enum logic {ST_IDLE, ST_OWN} arb_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        return SEG_HEX[{h, 3'b000} +: 8];
    endfunction

    // Highest-index requester; only meaningful when r is non-zero.
    function automatic logic [1:0] top_req(input logic [2:0] r);
        return r[2] ? SRC_BANNER : r[1] ? SRC_RESULT : SRC_ENTRY;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: refresh prescaler and digit index for the multiplexed display.
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   slot_tick   out  high on the last cycle of each digit slot
//   frame_tick  out  high on the last cycle of the digit 0 slot (frame end)
//   digit_idx   out  currently enabled digit (3 = leftmost), scans 3,2,1,0
//   idx_nxt     out  digit that becomes enabled at the next slot_tick
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 25000
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic       slot_tick,
    output logic       frame_tick,
    output logic [1:0] digit_idx,
    output logic [1:0] idx_nxt
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] presc;

    assign slot_tick  = presc == CW'(REFRESH_DIV - 1);
    assign frame_tick = slot_tick && digit_idx == 2'd0;
    // Two-bit wrap gives the 0 -> 3 step for free.
    assign idx_nxt    = digit_idx - 2'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            digit_idx <= 2'(DIGITS - 1);
        end else begin
            presc <= slot_tick ? '0 : presc + 1'b1;
            if (slot_tick)
                digit_idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one 4-digit multiplexed 7-segment display between
// three sources (0 entry, 1 result, 2 banner) with fixed priority 2 > 1 > 0.
// Grant changes only at frame boundaries and is held at least MIN_FRAMES frames.
// Optional blink support is enabled by defining SEG_BLINK_EN.
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   req[2:0]    in   level request per source
//   seg0..seg2  in   {d3,d2,d1,d0} active-low patterns per source
//   blink[2:0]  in   per-source blink enable (SEG_BLINK_EN only)
//   grant[2:0]  out  one-hot owner, 000 when idle
//   frame_tick  out  pulse on the last cycle of each frame
//   anodes[3:0] out  active-low digit enables
//   cathods[7:0]out  active-low segments of the enabled digit
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 25000,
    parameter int MIN_FRAMES   = 8
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 50
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [31:0] seg0,
    input  logic [31:0] seg1,
    input  logic [31:0] seg2,
`ifdef SEG_BLINK_EN
    input  logic [2:0]  blink,
`endif
    output logic [2:0]  grant,
    output logic        frame_tick,
    output logic [3:0]  anodes,
    output logic [7:0]  cathods
);

    localparam int HW = $clog2(MIN_FRAMES + 1);

    arb_state_t    state, state_nxt;
    logic [1:0]    owner, owner_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic          slot_tick;
    logic [1:0]    digit_idx, idx_nxt;
    logic [31:0]   src_word;
    logic [7:0]    pattern;
    logic          blank;

    seg_scan_timer #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
        .clock      (clock),
        .reset_n    (reset_n),
        .slot_tick  (slot_tick),
        .frame_tick (frame_tick),
        .digit_idx  (digit_idx),
        .idx_nxt    (idx_nxt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            owner <= SRC_ENTRY;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            hold  <= hold_nxt;
        end
    end

    // Once the hold is satisfied (or when idle) the highest requester always
    // wins: it is either a higher source, the current owner still requesting,
    // or the best remaining one after the owner dropped.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        hold_nxt  = hold;
        if (frame_tick) begin
            hold_nxt = (hold == HW'(MIN_FRAMES)) ? hold : hold + 1'b1;
            if (state == ST_IDLE || hold == HW'(MIN_FRAMES)) begin
                state_nxt = |req ? ST_OWN : ST_IDLE;
                owner_nxt = |req ? top_req(req) : owner;
            end
            if (state_nxt != state || owner_nxt != owner)
                hold_nxt = '0;
        end
    end

    assign grant = (state == ST_OWN) ? 3'b001 << owner : 3'b000;

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          own_blink, blink_rst, blink_wrap;

    assign own_blink  = state == ST_OWN && blink[owner];
    assign blink_rst  = !own_blink || state_nxt != state || owner_nxt != owner;
    assign blink_wrap = frame_tick && blink_cnt == BW'(BLINK_FRAMES - 1);
    // Use the phase as it will be after this edge so a frame is blanked whole.
    assign blank      = !blink_rst && (blink_phase ^ blink_wrap);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
            blink_phase <= blink_phase ^ blink_wrap;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Cathods follow the owner that will hold the display after this edge so a
    // new grant shows its own pattern from the first slot of its frame.
    assign src_word = (owner_nxt == SRC_BANNER) ? seg2 :
                      (owner_nxt == SRC_RESULT) ? seg1 : seg0;
    assign pattern  = (state_nxt == ST_IDLE || blank) ? SEG_BLANK :
                      src_word[{idx_nxt, 3'b000} +: 8];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anodes  <= 4'b0111;
            cathods <= SEG_BLANK;
        end else if (slot_tick) begin
            anodes  <= ~(4'b0001 << idx_nxt);
            cathods <= pattern;
        end
    end

endmodule
